// File: rtl/operand_packer_pkg.sv
// rtl/operand_packer_pkg.sv - shared types and width check for the operand packer
package operand_packer_pkg;

  localparam int unsigned PACK_RATIO = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_e;

  function automatic bit width_ok(input int unsigned n, input int unsigned m);
    return m == PACK_RATIO * n;
  endfunction

endpackage

// File: rtl/packer_out_reg.sv
// rtl/packer_out_reg.sv - registered valid/ready output stage that holds data while stalled
module packer_out_reg #(
  parameter int unsigned W = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         hs_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // The caller only asserts load_i when the slot is free, so a load always wins.
  always_comb begin
    valid_d = valid_q & ~ready_i;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign hs_o    = valid_q & ready_i;

endmodule

// File: rtl/operand_packer.sv
// rtl/operand_packer.sv - packs operand pairs {second, first} with flush of a held odd word
module operand_packer
  import operand_packer_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned M  = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [M-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_odd,
  output logic [CW-1:0] pair_count
);

  if (!width_ok(N, M)) begin : g_width_check
    $error("operand_packer: M must equal 2*N");
  end

  pack_state_e   state_q, state_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          slot_free;
  logic          in_hs;
  logic          out_hs;
  logic          load;
  logic [M-1:0]  load_data;
  logic          load_odd;
  logic [M:0]    reg_data;

  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = ~rst & ((state_q == ST_EMPTY) | slot_free);
  assign in_hs     = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    load      = 1'b0;
    load_data = '0;
    load_odd  = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_hs) begin
          state_d = ST_HALF;
          lo_d    = in_data;
        end
      end
      ST_HALF: begin
        // A pair completion takes priority; flush only fires when no word is offered.
        if (in_hs) begin
          state_d   = ST_EMPTY;
          load      = 1'b1;
          load_data = M'({in_data, lo_q});
        end else if (~in_valid & flush & slot_free) begin
          state_d   = ST_EMPTY;
          load      = 1'b1;
          load_data = M'({{N{1'b0}}, lo_q});
          load_odd  = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign cnt_d = out_hs ? cnt_q + CW'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  packer_out_reg #(
    .W(M + 1)
  ) u_out_reg (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .load_data_i({load_odd, load_data}),
    .ready_i    (out_ready),
    .valid_o    (out_valid),
    .data_o     (reg_data),
    .hs_o       (out_hs)
  );

  assign out_data   = reg_data[M-1:0];
  assign out_odd    = reg_data[M];
  assign pair_count = cnt_q;

endmodule
